if_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline. It owns the program counter and drives the synchronous-read instruction memory's address and chip-enable. It pairs each returned instruction word with the PC it was fetched from and hands both to decode. It also applies stall and redirect requests (branch/jump targets) coming back from decode and the hazard unit, and halts on a misaligned fetch target.

---
 rtl/if_stage.sv | 117 +++++++++++
 tb/tb_if_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the MIPS pipeline.
// Owns the PC, drives the synchronous-read instruction memory, pairs each
// returned word with the PC it came from, and applies stall / redirect
// requests. A misaligned fetch target parks the stage in a sticky error state.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 13
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic [31:0]      inst_in,
    output logic             imce,
    output logic [IM_AW-1:0] imaddr_d4,
    output logic [31:0]      inst_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4,
    output logic             inst_valid,
    output logic             fetch_err,
    output logic [31:0]      err_pc
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HOLD = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;          // address issued this cycle
    logic [31:0] r_pc_o;        // address issued on the last enabled cycle
    logic        r_inst_valid;
    logic        r_pend_valid;  // redirect captured while stalled
    logic [31:0] r_pend_pc;
    logic        r_fetch_err;
    logic [31:0] r_err_pc;

    logic [31:0] w_target;
    logic        w_misaligned;

    // Next-PC select: a redirect parked during a stall outranks a live one,
    // which in turn outranks sequential fetch. Wraps modulo 2^32.
    always_comb begin
        w_target = r_pc + 32'd4;
        if (r_pend_valid)
            w_target = r_pend_pc;
        else if (redirect_valid)
            w_target = redirect_pc;
    end

    assign w_misaligned = |w_target[1:0];

    // Memory is enabled during reset so it clears its output word; a stall
    // drops the enable in the same cycle so the memory holds the word that
    // pairs with pc_o.
    assign imce = ~cpu_rst_n | ((r_state != S_ERR) & ~stall);

    // High PC bits are dropped: the instruction memory aliases.
    assign imaddr_d4  = r_pc[IM_AW+1:2];
    assign inst_o     = r_inst_valid ? inst_in : 32'h0;
    assign pc_o       = r_pc_o;
    assign pc_plus4   = r_pc_o + 32'd4;
    assign inst_valid = r_inst_valid;
    assign fetch_err  = r_fetch_err;
    assign err_pc     = r_err_pc;

    // Fetch FSM: RUN/HOLD advance the PC on any non-stalled cycle (HOLD just
    // records that we came out of a stall); ERR is left only through reset.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            r_state      <= S_RUN;
            r_pc         <= RESET_PC;
            r_pc_o       <= 32'h0;
            r_inst_valid <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 32'h0;
            r_fetch_err  <= 1'b0;
            r_err_pc     <= 32'h0;
        end else begin
            case (r_state)
                S_RUN, S_HOLD: begin
                    if (stall) begin
                        // Freeze fetch; never lose a redirect that lands here.
                        r_state <= S_HOLD;
                        if (redirect_valid) begin
                            r_pend_valid <= 1'b1;
                            r_pend_pc    <= redirect_pc;
                        end
                    end else if (w_misaligned) begin
                        // Target rejected before load: pc stays put.
                        r_state      <= S_ERR;
                        r_fetch_err  <= 1'b1;
                        r_err_pc     <= w_target;
                        r_inst_valid <= 1'b0;
                    end else begin
                        // The word issued this cycle is delivered next cycle,
                        // which is what gives the branch delay slot.
                        r_state      <= S_RUN;
                        r_pc_o       <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_pc         <= w_target;
                        r_pend_valid <= 1'b0;
                    end
                end
                S_ERR: begin
                    r_inst_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized traffic,
// all checked against a behavioural fetch model kept in this module.
module tb_if_stage;

    localparam int          AW  = 13;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic          rv;
    logic [31:0]   rpc;
    logic [31:0]   inst_in;
    logic          imce;
    logic [AW-1:0] imaddr;
    logic [31:0]   inst_o;
    logic [31:0]   pc_o;
    logic [31:0]   pc_plus4;
    logic          inst_valid;
    logic          fetch_err;
    logic [31:0]   err_pc;

    int total = 0;
    int bad   = 0;

    if_stage #(.RESET_PC(RPC), .IM_AW(AW)) dut (
        .cpu_clk_50M   (clk),
        .cpu_rst_n     (rst_n),
        .stall         (stall),
        .redirect_valid(rv),
        .redirect_pc   (rpc),
        .inst_in       (inst_in),
        .imce          (imce),
        .imaddr_d4     (imaddr),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .pc_plus4      (pc_plus4),
        .inst_valid    (inst_valid),
        .fetch_err     (fetch_err),
        .err_pc        (err_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Content of each instruction-memory word, a fixed scramble of its address.
    function automatic logic [31:0] memword(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Synchronous-read instruction memory; cleared while reset is applied.
    logic [31:0] mem_q = 32'h0;
    always @(posedge clk) if (imce) mem_q <= rst_n ? memword(imaddr) : 32'h0;
    assign inst_in = mem_q;

    // Behavioural model: what fetch should be doing, in terms of the issued
    // address, the delivered address, a parked redirect and a halt flag.
    logic [31:0] m_pc, m_pco, m_ppc, m_errpc;
    logic        m_valid, m_pend, m_err;

    task automatic model_step();
        logic [31:0] tgt;
        if (!rst_n) begin
            m_pc = RPC; m_pco = 0; m_valid = 0; m_pend = 0; m_err = 0; m_errpc = 0;
        end else if (m_err) begin
            m_valid = 0;
        end else if (stall) begin
            if (rv) begin m_pend = 1; m_ppc = rpc; end
        end else begin
            tgt = m_pend ? m_ppc : (rv ? rpc : m_pc + 32'd4);
            if (tgt % 4 != 0) begin
                m_err = 1; m_errpc = tgt; m_valid = 0;
            end else begin
                m_pco = m_pc; m_valid = 1; m_pc = tgt; m_pend = 0;
            end
        end
    endtask

    // One clock: update the model at the edge, return at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; stall = 0; rv = 0; rpc = 0;
        cyc(); cyc(); #1;
        total += 7;
        if (imce !== 1'b1)      begin bad++; $display("FAIL reset_imce got=%0h exp=1", imce); end
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", inst_valid); end
        if (pc_o !== 32'h0)      begin bad++; $display("FAIL reset_pc_o got=%0h exp=0", pc_o); end
        if (fetch_err !== 1'b0)  begin bad++; $display("FAIL reset_err got=%0h exp=0", fetch_err); end
        if (err_pc !== 32'h0)    begin bad++; $display("FAIL reset_err_pc got=%0h exp=0", err_pc); end
        if (imaddr !== '0)       begin bad++; $display("FAIL reset_addr got=%0h exp=0", imaddr); end
        if (inst_o !== 32'h0)    begin bad++; $display("FAIL reset_inst got=%0h exp=0", inst_o); end
    endtask

    task automatic test_freerun();
        rst_n = 1; #1;
        total += 2;
        if (imaddr !== 0)        begin bad++; $display("FAIL run_c0_addr got=%0h exp=0", imaddr); end
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL run_c0_valid got=%0h exp=0", inst_valid); end
        for (int k = 1; k <= 3; k++) begin
            cyc(); #1;
            total += 5;
            if (imaddr !== AW'(k))   begin bad++; $display("FAIL run_addr c%0d got=%0h exp=%0h", k, imaddr, k); end
            if (inst_valid !== 1'b1) begin bad++; $display("FAIL run_valid c%0d got=%0h exp=1", k, inst_valid); end
            if (pc_o !== 32'(4*(k-1))) begin bad++; $display("FAIL run_pc_o c%0d got=%0h exp=%0h", k, pc_o, 4*(k-1)); end
            if (pc_plus4 !== 32'(4*k)) begin bad++; $display("FAIL run_pc4 c%0d got=%0h exp=%0h", k, pc_plus4, 4*k); end
            if (inst_o !== memword(AW'(k-1))) begin bad++; $display("FAIL run_inst c%0d got=%0h exp=%0h", k, inst_o, memword(AW'(k-1))); end
        end
        cyc();
    endtask

    // Entered with pc=0x10, pc_o=0x0C.
    task automatic test_stall();
        stall = 1; #1;
        for (int i = 0; i < 3; i++) begin
            total += 4;
            if (imce !== 1'b0)          begin bad++; $display("FAIL stall_imce i%0d got=%0h exp=0", i, imce); end
            if (pc_o !== 32'h0C)        begin bad++; $display("FAIL stall_pc_o i%0d got=%0h exp=c", i, pc_o); end
            if (inst_o !== memword(3))  begin bad++; $display("FAIL stall_inst i%0d got=%0h exp=%0h", i, inst_o, memword(3)); end
            if (imaddr !== 4)           begin bad++; $display("FAIL stall_addr i%0d got=%0h exp=4", i, imaddr); end
            cyc(); #1;
        end
        stall = 0; #1;
        total += 1;
        if (imce !== 1'b1) begin bad++; $display("FAIL unstall_imce got=%0h exp=1", imce); end
        cyc(); #1;
        total += 2;
        if (pc_o !== 32'h10)       begin bad++; $display("FAIL unstall_pc_o got=%0h exp=10", pc_o); end
        if (inst_o !== memword(4)) begin bad++; $display("FAIL unstall_inst got=%0h exp=%0h", inst_o, memword(4)); end
    endtask

    task automatic test_redirect();
        cyc(); cyc(); #1;
        total += 1;
        if (imaddr !== 7) begin bad++; $display("FAIL redir_pre_addr got=%0h exp=7", imaddr); end
        rv = 1; rpc = 32'h60;
        cyc(); rv = 0; #1;
        total += 3;
        if (pc_o !== 32'h1C)       begin bad++; $display("FAIL redir_slot_pc got=%0h exp=1c", pc_o); end
        if (inst_o !== memword(7)) begin bad++; $display("FAIL redir_slot_inst got=%0h exp=%0h", inst_o, memword(7)); end
        if (imaddr !== 24)         begin bad++; $display("FAIL redir_addr got=%0h exp=18", imaddr); end
        cyc(); #1;
        total += 2;
        if (pc_o !== 32'h60)        begin bad++; $display("FAIL redir_tgt_pc got=%0h exp=60", pc_o); end
        if (inst_o !== memword(24)) begin bad++; $display("FAIL redir_tgt_inst got=%0h exp=%0h", inst_o, memword(24)); end
    endtask

    // Entered with pc=0x64.
    task automatic test_stall_redirect();
        stall = 1; rv = 1; rpc = 32'h80;
        cyc(); rv = 0;
        cyc(); stall = 0; #1;
        total += 2;
        if (imce !== 1'b1) begin bad++; $display("FAIL sr_imce got=%0h exp=1", imce); end
        if (imaddr !== 25) begin bad++; $display("FAIL sr_hold_addr got=%0h exp=19", imaddr); end
        cyc(); #1;
        total += 2;
        if (imaddr !== 32)   begin bad++; $display("FAIL sr_tgt_addr got=%0h exp=20", imaddr); end
        if (pc_o !== 32'h64) begin bad++; $display("FAIL sr_pc_o got=%0h exp=64", pc_o); end
        cyc(); #1;
        total += 3;
        if (imaddr !== 33)          begin bad++; $display("FAIL sr_pend_clear got=%0h exp=21", imaddr); end
        if (pc_o !== 32'h80)        begin bad++; $display("FAIL sr_pc_o2 got=%0h exp=80", pc_o); end
        if (inst_o !== memword(32)) begin bad++; $display("FAIL sr_inst got=%0h exp=%0h", inst_o, memword(32)); end
    endtask

    // Entered with pc=0x84.
    task automatic test_misaligned();
        rv = 1; rpc = 32'h42;
        cyc(); rv = 0; #1;
        total += 6;
        if (fetch_err !== 1'b1)  begin bad++; $display("FAIL mis_err got=%0h exp=1", fetch_err); end
        if (err_pc !== 32'h42)   begin bad++; $display("FAIL mis_err_pc got=%0h exp=42", err_pc); end
        if (imce !== 1'b0)       begin bad++; $display("FAIL mis_imce got=%0h exp=0", imce); end
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL mis_valid got=%0h exp=0", inst_valid); end
        if (inst_o !== 32'h0)    begin bad++; $display("FAIL mis_inst got=%0h exp=0", inst_o); end
        if (imaddr !== 33)       begin bad++; $display("FAIL mis_pc_frozen got=%0h exp=21", imaddr); end
        for (int i = 0; i < 4; i++) begin
            rv = 1; rpc = 32'h100 + 32'(i * 4); stall = i[0];
            cyc(); #1;
            total += 5;
            if (fetch_err !== 1'b1)  begin bad++; $display("FAIL mis_sticky i%0d got=%0h exp=1", i, fetch_err); end
            if (err_pc !== 32'h42)   begin bad++; $display("FAIL mis_keep_pc i%0d got=%0h exp=42", i, err_pc); end
            if (imaddr !== 33)       begin bad++; $display("FAIL mis_ignore i%0d got=%0h exp=21", i, imaddr); end
            if (inst_valid !== 1'b0) begin bad++; $display("FAIL mis_valid2 i%0d got=%0h exp=0", i, inst_valid); end
            if (imce !== 1'b0)       begin bad++; $display("FAIL mis_imce2 i%0d got=%0h exp=0", i, imce); end
        end
        rv = 0; stall = 0;
    endtask

    task automatic test_reset_hold();
        rst_n = 0; cyc(); rst_n = 1; #1;
        total += 2;
        if (fetch_err !== 1'b0) begin bad++; $display("FAIL rh_err_clr got=%0h exp=0", fetch_err); end
        if (imaddr !== 0)       begin bad++; $display("FAIL rh_addr0 got=%0h exp=0", imaddr); end
        cyc(); cyc();
        stall = 1; rv = 1; rpc = 32'h200;
        cyc(); rv = 0;
        cyc();
        rst_n = 0; cyc();
        rst_n = 1; stall = 0; #1;
        total += 3;
        if (imaddr !== 0)        begin bad++; $display("FAIL rh_restart got=%0h exp=0", imaddr); end
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL rh_valid got=%0h exp=0", inst_valid); end
        if (fetch_err !== 1'b0)  begin bad++; $display("FAIL rh_err got=%0h exp=0", fetch_err); end
        cyc(); #1;
        total += 3;
        if (imaddr !== 1)        begin bad++; $display("FAIL rh_pend_drop got=%0h exp=1", imaddr); end
        if (pc_o !== 32'h0)      begin bad++; $display("FAIL rh_pc_o got=%0h exp=0", pc_o); end
        if (inst_valid !== 1'b1) begin bad++; $display("FAIL rh_valid2 got=%0h exp=1", inst_valid); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] e_inst;
        for (int n = 0; n < 800; n++) begin
            rst_n = ($urandom_range(99) != 0);
            stall = ($urandom_range(3) == 0);
            rv    = ($urandom_range(5) == 0);
            r     = $urandom;
            case ($urandom_range(19))
                0:       rpc = {r[31:2], 2'($urandom_range(1, 3))};
                1, 2:    rpc = 32'hFFFF_FFF0 | {28'h0, r[3:2], 2'b00};
                default: rpc = {r[31:2], 2'b00};
            endcase
            #1;
            e_inst = m_valid ? memword(m_pco[AW+1:2]) : 32'h0;
            total += 8;
            if (imce !== (~rst_n | (~m_err & ~stall))) begin bad++; $display("FAIL rnd_imce n%0d got=%0h exp=%0h", n, imce, ~rst_n | (~m_err & ~stall)); end
            if (imaddr !== m_pc[AW+1:2])   begin bad++; $display("FAIL rnd_addr n%0d got=%0h exp=%0h", n, imaddr, m_pc[AW+1:2]); end
            if (inst_valid !== m_valid)    begin bad++; $display("FAIL rnd_valid n%0d got=%0h exp=%0h", n, inst_valid, m_valid); end
            if (pc_o !== m_pco)            begin bad++; $display("FAIL rnd_pc_o n%0d got=%0h exp=%0h", n, pc_o, m_pco); end
            if (pc_plus4 !== m_pco + 32'd4) begin bad++; $display("FAIL rnd_pc4 n%0d got=%0h exp=%0h", n, pc_plus4, m_pco + 32'd4); end
            if (inst_o !== e_inst)         begin bad++; $display("FAIL rnd_inst n%0d got=%0h exp=%0h", n, inst_o, e_inst); end
            if (fetch_err !== m_err)       begin bad++; $display("FAIL rnd_err n%0d got=%0h exp=%0h", n, fetch_err, m_err); end
            if (err_pc !== m_errpc)        begin bad++; $display("FAIL rnd_err_pc n%0d got=%0h exp=%0h", n, err_pc, m_errpc); end
            cyc();
        end
    endtask

    initial begin
        rst_n = 0; stall = 0; rv = 0; rpc = 0;
        m_pc = RPC; m_pco = 0; m_ppc = 0; m_errpc = 0;
        m_valid = 0; m_pend = 0; m_err = 0;
        test_reset();
        test_freerun();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_misaligned();
        test_reset_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
